// File: rtl/fxdiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fxdiv_pkg: shared types and sizing helpers for seq_fixed_point_div    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fxdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fxdiv_state_t;

  // Left shift applied to |a| so the quotient carries WOF+1 fraction bits.
  function automatic int fxdiv_sh(input int wof, input int wifa, input int wifb);
    return wof + 1 + wifb - wifa;
  endfunction

  function automatic int fxdiv_dw(input int wiia, input int wifa, input int sh);
    return wiia + wifa + sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxdiv_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fxdiv_round_sat: rounds, signs and saturates the raw quotient         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fxdiv_round_sat #(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int DW    = 25,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic [DW-1:0]      q,
  input  logic               sign,
  input  logic               zero_dividend,
  input  logic               div0,
  output logic [WOI+WOF-1:0] out,
  output logic               upflow,
  output logic               downflow
);

  localparam int W  = WOI + WOF;
  localparam int MW = ((DW > W) ? DW : W) + 1;

  logic [MW-1:0] w_mag;
  logic [MW-1:0] w_neg_lim;
  logic [MW-1:0] w_pos_lim;
  logic          w_ovf;
  logic [W-1:0]  w_max;
  logic [W-1:0]  w_min;

  always_comb begin
    w_max     = {1'b0, {(W-1){1'b1}}};
    w_min     = {1'b1, {(W-1){1'b0}}};
    // q holds one extra fraction bit; it is the round bit
    w_mag     = MW'(q >> 1) + ((ROUND != 0) ? MW'(q[0]) : '0);
    w_neg_lim = MW'(1) << (W - 1);
    w_pos_lim = w_neg_lim - MW'(1);
    w_ovf     = sign ? (w_mag > w_neg_lim) : (w_mag > w_pos_lim);

    out      = W'(sign ? -w_mag : w_mag);
    upflow   = w_ovf;
    downflow = !zero_dividend && (w_mag == '0);
    if (w_ovf && (ROOF != 0)) begin
      out = sign ? w_min : w_max;
    end

    if (div0) begin
      downflow = 1'b0;
      upflow   = !zero_dividend;
      out      = zero_dividend ? '0 : (sign ? w_min : w_max);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_fixed_point_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_fixed_point_div: iterative signed fixed-point divider, one bit/clk|
// | Optional inexact output enabled by FIXEDPOINT_DIV_INEXACT_EN.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module seq_fixed_point_div
  import fxdiv_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIIA+WIFA-1:0] ina,
  input  logic [WIIB+WIFB-1:0] inb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WOI+WOF-1:0]   out,
  output logic                 upflow,
  output logic                 downflow,
`ifdef FIXEDPOINT_DIV_INEXACT_EN
  output logic                 inexact,
`endif
  output logic                 div0
);

  localparam int WA = WIIA + WIFA;
  localparam int WB = WIIB + WIFB;
  localparam int W  = WOI + WOF;
  localparam int SH = fxdiv_sh(WOF, WIFA, WIFB);
  localparam int DW = fxdiv_dw(WIIA, WIFA, SH);
  localparam int CW = $clog2(DW + 1);

  if (SH < 0) begin : g_sh_check
    $error("seq_fixed_point_div: WOF+1+WIFB-WIFA must be non-negative");
  end

  fxdiv_state_t r_state, w_state_nxt;

  logic          r_sign, r_zero, r_div0;
  logic [DW-1:0] r_num, r_q;
  logic [WB-1:0] r_den, r_rem;
  logic [CW-1:0] r_cnt;

  logic [WA-1:0] w_abs_a;
  logic [WB-1:0] w_abs_b;
  logic [WB:0]   w_part;
  logic          w_ge;
  logic [W-1:0]  w_out;
  logic          w_upflow, w_downflow;

  assign w_abs_a = ina[WA-1] ? -ina : ina;
  assign w_abs_b = inb[WB-1] ? -inb : inb;
  assign w_part  = {r_rem, r_num[DW-1]};
  assign w_ge    = (w_part >= {1'b0, r_den});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        // Counter reaching zero leaves one cycle to register the rounded result
        if (r_div0 || (r_cnt == '0)) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  fxdiv_round_sat #(
    .WOI  (WOI),
    .WOF  (WOF),
    .DW   (DW),
    .ROOF (ROOF),
    .ROUND(ROUND)
  ) u_round_sat (
    .q            (r_q),
    .sign         (r_sign),
    .zero_dividend(r_zero),
    .div0         (r_div0),
    .out          (w_out),
    .upflow       (w_upflow),
    .downflow     (w_downflow)
  );

`ifdef FIXEDPOINT_DIV_INEXACT_EN
  logic w_inexact;
  assign w_inexact = !r_div0 && ((r_rem != '0) || r_q[0]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_div0   <= 1'b0;
      r_num    <= '0;
      r_q      <= '0;
      r_den    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      out      <= '0;
      upflow   <= 1'b0;
      downflow <= 1'b0;
      div0     <= 1'b0;
`ifdef FIXEDPOINT_DIV_INEXACT_EN
      inexact  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= ina[WA-1] ^ inb[WB-1];
            r_zero <= (ina == '0);
            r_div0 <= (inb == '0);
            r_num  <= DW'(w_abs_a) << SH;
            r_den  <= w_abs_b;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= CW'(DW);
          end
        end
        CALC: begin
          if (r_div0 || (r_cnt == '0)) begin
            out      <= w_out;
            upflow   <= w_upflow;
            downflow <= w_downflow;
            div0     <= r_div0;
`ifdef FIXEDPOINT_DIV_INEXACT_EN
            inexact  <= w_inexact;
`endif
          end else begin
            r_rem <= WB'(w_ge ? (w_part - {1'b0, r_den}) : w_part);
            r_q   <= {r_q[DW-2:0], w_ge};
            r_num <= r_num << 1;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_fixed_point_div.sv
`default_nettype none
// Scoreboard bench for seq_fixed_point_div (default 8.8/8.8 -> 8.8, ROOF=1, ROUND=1).
module tb_seq_fixed_point_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] ina = '0;
  logic [15:0] inb = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out;
  logic        upflow, downflow, div0;
`ifdef FIXEDPOINT_DIV_INEXACT_EN
  logic        inexact;
`endif

  typedef struct packed {
    logic [15:0] o;
    logic        up;
    logic        dn;
    logic        d0;
    logic        ix;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   bp_mode = 1;
  logic forced_ready = 1'b1;

  always #5 clk = ~clk;

  seq_fixed_point_div dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ina      (ina),
    .inb      (inb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .upflow   (upflow),
    .downflow (downflow),
`ifdef FIXEDPOINT_DIV_INEXACT_EN
    .inexact  (inexact),
`endif
    .div0     (div0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: real quotient a/b scaled by 2^8, rounded half away from zero.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint sa, sbv, ma, mb, mag, res;
    bit     neg;
    e   = '0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    if (sbv == 0) begin
      e.d0 = 1'b1;
      if (sa > 0) begin e.o = 16'h7FFF; e.up = 1'b1; end
      else if (sa < 0) begin e.o = 16'h8000; e.up = 1'b1; end
      return e;
    end
    neg  = (sa < 0) != (sbv < 0);
    mag  = (ma * 512 + mb) / (2 * mb);
    e.ix = ((ma * 512) % (2 * mb)) != 0;
    e.dn = (ma != 0) && (mag == 0);
    if (!neg && mag > 32767) begin e.o = 16'h7FFF; e.up = 1'b1; end
    else if (neg && mag > 32768) begin e.o = 16'h8000; e.up = 1'b1; end
    else begin
      res = neg ? -mag : mag;
      e.o = res[15:0];
    end
    return e;
  endfunction

  function automatic exp_t dir(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] o, input logic up, input logic dn,
                               input logic d0);
    exp_t e;
    e    = model(a, b);
    e.o  = o;
    e.up = up;
    e.dn = dn;
    e.d0 = d0;
    return e;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    ina = a;
    inb = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = (bp_mode != 0) ? forced_ready : ($urandom_range(0, 3) != 0);
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out=%0h, expected no result", out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", 32'(out), 32'(e.o));
          chk("upflow", 32'(upflow), 32'(e.up));
          chk("downflow", 32'(downflow), 32'(e.dn));
          chk("div0", 32'(div0), 32'(e.d0));
`ifdef FIXEDPOINT_DIV_INEXACT_EN
          chk("inexact", 32'(inexact), 32'(e.ix));
`endif
        end
      end
    end
  end

  initial begin
    int          n;
    logic [15:0] held;
    logic [15:0] a, b;
    logic [15:0] specials [5];
    specials = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};

    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_flags", {29'd0, upflow, downflow, div0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Latency from accept edge to out_valid
    send(16'h0300, 16'h0200, dir(16'h0300, 16'h0200, 16'h0180, 0, 0, 0));
    wait_valid(n);
    chk("latency", 32'(n), 32'd26);

    send(16'h0100, 16'h0300, dir(16'h0100, 16'h0300, 16'h0055, 0, 0, 0));
    send(16'hF880, 16'h0280, dir(16'hF880, 16'h0280, 16'hFD00, 0, 0, 0));
    send(16'h6400, 16'h0001, dir(16'h6400, 16'h0001, 16'h7FFF, 1, 0, 0));
    send(16'h0100, 16'h0000, dir(16'h0100, 16'h0000, 16'h7FFF, 1, 0, 1));
    send(16'h0000, 16'h0000, dir(16'h0000, 16'h0000, 16'h0000, 0, 0, 1));
    send(16'hFF00, 16'h0000, dir(16'hFF00, 16'h0000, 16'h8000, 1, 0, 1));
    send(16'h0001, 16'h7F00, dir(16'h0001, 16'h7F00, 16'h0000, 0, 1, 0));
    send(16'h8000, 16'h0100, dir(16'h8000, 16'h0100, 16'h8000, 0, 0, 0));

    // Backpressure: result must hold while out_ready is low
    wait_valid(n);
    @(posedge clk); #2;
    forced_ready = 1'b0;
    send(16'h0700, 16'hFE00, model(16'h0700, 16'hFE00));
    wait_valid(n);
    held = out;
    chk("bp_out_value", 32'(held), 32'h0000FC80);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_stable", 32'(out), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    forced_ready = 1'b1;
    wait_valid(n);
    repeat (3) @(posedge clk);

    // Reset in the middle of a division
    send(16'h1234, 16'h0345, model(16'h1234, 16'h0345));
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    send(16'h0A00, 16'h0400, dir(16'h0A00, 16'h0400, 16'h0280, 0, 0, 0));
    wait_valid(n);
    chk("post_reset_latency", 32'(n), 32'd26);

    // Randomized operands with random output backpressure
    bp_mode = 0;
    for (int i = 0; i < 120; i++) begin
      a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 3));
        1: b = specials[$urandom_range(0, 4)];
        default: b = 16'($urandom);
      endcase
      send(a, b, model(a, b));
    end

    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
